y_window_acc: RTL and testbench
===============================

# y_window_acc

Downstream consumer of the 14-bit arithmetic result `y` and its qualifier `e` produced by `module_top`. Captures every qualified sample and accumulates it over a fixed window of 2^LOG2_WIN samples. At the end of each window it publishes the window sum, the floor average and, optionally, the peak sample, with a one-cycle valid pulse. The block feeds result logging and threshold logic.

## Interface
- WIDTH, 14, sample width; matches `y` of `module_top`
- LOG2_WIN, 3, log2 of window length; legal range 1..8
- clk  input  1  rising-edge clock, shared with `module_top`
- rst_n  input  1  synchronous active-low reset
- e  input  1  sample qualifier; `y_in` is captured on an edge where e=1
- y_in  input  WIDTH  unsigned sample, driven from `module_top` y
- clr  input  1  synchronous window abort
- sum  output  WIDTH+LOG2_WIN  sum of the last completed window
- avg  output  WIDTH  sum >> LOG2_WIN, floor
- peak  output  WIDTH  largest sample of the last completed window (PEAK_DET_EN only)
- out_valid  output  1  one-cycle pulse when sum, avg and peak update
- win_cnt  output  LOG2_WIN  samples captured in the current window

## Operation
- Internal state: accumulator `acc` (WIDTH+LOG2_WIN bits), sample counter `cnt` (LOG2_WIN bits), running max `pk`.
- The window has two states:
  - EMPTY: cnt=0, acc=0.
  - FILL: 0<cnt<2^LOG2_WIN.
- Sample (e=1, clr=0): acc+=y_in; cnt+=1; pk=max(pk,y_in).
- Final sample of a window, i.e. cnt = 2^LOG2_WIN−1 with e=1:
  - Update: sum←acc+y_in; avg←(acc+y_in)>>LOG2_WIN; peak←max(pk,y_in).
  - Then out_valid←1, acc←0, cnt←0 (wraps), pk←0.
  - Return to EMPTY.
- Back-to-back windows: a sample on the cycle out_valid is high belongs to the next window. No dead cycle.
- e=0 cycles: state holds. Gaps of any length are allowed inside a window.
- Accumulator is sized so it cannot overflow: max sum = (2^WIDTH−1)·2^LOG2_WIN.
- All arithmetic is unsigned.
- clr=1 (with rst_n=1):
  - acc, cnt and pk are zeroed and out_valid=0.
  - A concurrent e=1 sample is discarded.
  - sum, avg and peak keep their last published values.
- rst_n=0 has priority over clr and e. Reset mid-window discards the partial window.

## Timing
- Reset values:
  - sum=0, avg=0, peak=0.
  - out_valid=0, win_cnt=0.
  - acc=0, cnt=0, pk=0.
- All outputs are registered; there are no combinational input-to-output paths.
- Latency: sum, avg, peak and out_valid change on the same edge that captures the final sample of a window. They are visible for one cycle in which out_valid=1; the data stays stable until the next window completes.
- Throughput: one sample per cycle sustained.
- win_cnt reflects cnt after the current edge. It reads 0 on the out_valid cycle.

## Configuration
- PEAK_DET_EN defined: the `pk` register and comparator are built, and peak behaves as described above.
- PEAK_DET_EN undefined: no `pk` logic is built and peak is tied to 0. The port stays present so instantiations do not change.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with e=1, y_in=100. Required response: sum=0, avg=0, peak=0, out_valid=0, win_cnt=0. No window completes 7 cycles after release unless samples are given.
- Full window: LOG2_WIN=3, 8 consecutive samples y_in=2097. Required response: out_valid=1 on the 8th capture edge, sum=16776, avg=2097, peak=2097, win_cnt=0.
- Gapped window: samples 10,20,…,80 with one e=0 cycle between each. Required response: single out_valid after 80, sum=360, avg=45, peak=80 (peak=0 without PEAK_DET_EN).
- Extremes: 8 samples of 16383. Required response: sum=131064, avg=16383. Then 8 samples of 0,0,0,0,0,0,0,7. Required response: sum=7, avg=0, peak=7.
- Clear: 5 samples of 50, then clr=1 together with e=1 y_in=999, then 8 samples of 1. Required response: exactly one out_valid, with sum=8, avg=1, peak=1. The previous sum is held until then.
- Back-to-back: 16 continuous samples, 1..16. Required response: out_valid on capture edges 8 and 16. First window: sum=36, avg=4, peak=8. Second window: sum=100, avg=12, peak=16.

Source files
------------

// File: rtl/y_window_acc.sv
// ============================================================================
// Module   : y_window_acc
// Summary  : Accumulates qualified samples over windows of 2^LOG2_WIN samples.
//            It publishes the sum, the floor average and the peak sample.
//            Peak detection is built only when PEAK_DET_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module y_window_acc #(
  parameter int WIDTH    = 14,
  parameter int LOG2_WIN = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      e,
  input  logic [WIDTH-1:0]          y_in,
  input  logic                      clr,
  output logic [WIDTH+LOG2_WIN-1:0] sum,
  output logic [WIDTH-1:0]          avg,
  output logic [WIDTH-1:0]          peak,
  output logic                      out_valid,
  output logic [LOG2_WIN-1:0]       win_cnt
);

  localparam int                  ACC_W    = WIDTH + LOG2_WIN;
  localparam logic [LOG2_WIN-1:0] CNT_LAST = '1;

  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [LOG2_WIN-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0]    sum_q, sum_d;
  logic [WIDTH-1:0]    avg_q, avg_d;
  logic                valid_q, valid_d;
  logic [ACC_W-1:0]    acc_sum;
  logic                take, last;

  // A sample arriving with clr is discarded, so clr gates capture entirely.
  assign take    = e && !clr;
  assign last    = take && (cnt_q == CNT_LAST);
  assign acc_sum = acc_q + ACC_W'(y_in);

  always_comb begin
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    avg_d   = avg_q;
    valid_d = 1'b0;
    if (clr) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (last) begin
      sum_d   = acc_sum;
      avg_d   = acc_sum[ACC_W-1:LOG2_WIN];
      valid_d = 1'b1;
      acc_d   = '0;
      cnt_d   = '0;
    end else if (take) begin
      acc_d = acc_sum;
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      avg_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      avg_q   <= avg_d;
      valid_q <= valid_d;
    end
  end

`ifdef PEAK_DET_EN
  logic [WIDTH-1:0] pk_q, pk_d;
  logic [WIDTH-1:0] peak_q, peak_d;
  logic [WIDTH-1:0] pk_max;

  assign pk_max = (y_in > pk_q) ? y_in : pk_q;

  always_comb begin
    pk_d   = pk_q;
    peak_d = peak_q;
    if (clr) begin
      pk_d = '0;
    end else if (last) begin
      peak_d = pk_max;
      pk_d   = '0;
    end else if (take) begin
      pk_d = pk_max;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pk_q   <= '0;
      peak_q <= '0;
    end else begin
      pk_q   <= pk_d;
      peak_q <= peak_d;
    end
  end

  assign peak = peak_q;
`else
  assign peak = '0;
`endif

  assign sum       = sum_q;
  assign avg       = avg_q;
  assign out_valid = valid_q;
  assign win_cnt   = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_y_window_acc.sv
// ============================================================================
// Module   : tb_y_window_acc
// Summary  : Directed, table-driven self-checking bench for y_window_acc.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_y_window_acc;

  localparam int WIDTH    = 14;
  localparam int LOG2_WIN = 3;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic                      e;
  logic [WIDTH-1:0]          y_in;
  logic                      clr;
  logic [WIDTH+LOG2_WIN-1:0] sum;
  logic [WIDTH-1:0]          avg;
  logic [WIDTH-1:0]          peak;
  logic                      out_valid;
  logic [LOG2_WIN-1:0]       win_cnt;

  int checks = 0;
  int errors = 0;

  y_window_acc #(.WIDTH(WIDTH), .LOG2_WIN(LOG2_WIN)) dut (
    .clk(clk), .rst_n(rst_n), .e(e), .y_in(y_in), .clr(clr),
    .sum(sum), .avg(avg), .peak(peak), .out_valid(out_valid), .win_cnt(win_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic e;
    logic clr;
    int   y;
    logic exp_valid;
    int   exp_sum;
    int   exp_avg;
    int   exp_peak;
    int   exp_wc;
  } vec_t;

  vec_t vecs[64];
  int   nvec = 0;

  function automatic int pk(input int v);
`ifdef PEAK_DET_EN
    return v;
`else
    return 0;
`endif
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input int v, input int s, input int a,
                         input int p, input int wc);
    chk({tag, ".out_valid"}, out_valid, v);
    chk({tag, ".sum"}, sum, s);
    chk({tag, ".avg"}, avg, a);
    chk({tag, ".peak"}, peak, pk(p));
    chk({tag, ".win_cnt"}, win_cnt, wc);
  endtask

  // One window of eight consecutive samples: held results on the first seven
  // edges, fresh results with out_valid on the eighth.
  task automatic add_win(input int ys[8], input int ps, input int pa, input int pp,
                         input int ns, input int na, input int np);
    for (int k = 0; k < 8; k++) begin
      vecs[nvec].e         = 1'b1;
      vecs[nvec].clr       = 1'b0;
      vecs[nvec].y         = ys[k];
      vecs[nvec].exp_valid = (k == 7);
      vecs[nvec].exp_sum   = (k == 7) ? ns : ps;
      vecs[nvec].exp_avg   = (k == 7) ? na : pa;
      vecs[nvec].exp_peak  = (k == 7) ? np : pp;
      vecs[nvec].exp_wc    = (k == 7) ? 0 : k + 1;
      nvec++;
    end
  endtask

  initial begin
    int w[8];
    int nv;

    w = '{2097, 2097, 2097, 2097, 2097, 2097, 2097, 2097};
    add_win(w, 0, 0, 0, 16776, 2097, 2097);
    w = '{16383, 16383, 16383, 16383, 16383, 16383, 16383, 16383};
    add_win(w, 16776, 2097, 2097, 131064, 16383, 16383);
    w = '{0, 0, 0, 0, 0, 0, 0, 7};
    add_win(w, 131064, 16383, 16383, 7, 0, 7);
    w = '{1, 2, 3, 4, 5, 6, 7, 8};
    add_win(w, 7, 0, 7, 36, 4, 8);
    w = '{9, 10, 11, 12, 13, 14, 15, 16};
    add_win(w, 36, 4, 8, 100, 12, 16);

    // Reset held with a live sample on the input
    rst_n = 1'b0; e = 1'b1; y_in = 14'd100; clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all("reset", 0, 0, 0, 0, 0);
    end
    rst_n = 1'b1; e = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      chk_all("idle", 0, 0, 0, 0, 0);
    end

    // Full, extreme and back-to-back windows
    for (int i = 0; i < nvec; i++) begin
      e = vecs[i].e; clr = vecs[i].clr; y_in = WIDTH'(vecs[i].y);
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_sum,
              vecs[i].exp_avg, vecs[i].exp_peak, vecs[i].exp_wc);
    end

    // Gapped window: 10..80 with one idle cycle after each sample
    nv = 0;
    for (int k = 1; k <= 8; k++) begin
      e = 1'b1; y_in = WIDTH'(10 * k);
      step();
      if (out_valid) nv++;
      if (k < 8) chk_all("gap_mid", 0, 100, 12, 16, k);
      else       chk_all("gap_end", 1, 360, 45, 80, 0);
      e = 1'b0; y_in = '0;
      step();
      if (out_valid) nv++;
      chk("gap_idle.win_cnt", win_cnt, k % 8);
    end
    chk("gap.valid_count", nv, 1);

    // Clear mid-window discards the partial window and the concurrent sample
    nv = 0;
    for (int k = 1; k <= 5; k++) begin
      e = 1'b1; y_in = 14'd50;
      step();
      if (out_valid) nv++;
    end
    chk("pre_clr.win_cnt", win_cnt, 5);
    clr = 1'b1; e = 1'b1; y_in = 14'd999;
    step();
    if (out_valid) nv++;
    chk_all("clr", 0, 360, 45, 80, 0);
    clr = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      e = 1'b1; y_in = 14'd1;
      step();
      if (out_valid) nv++;
      if (k < 8) chk_all("post_clr", 0, 360, 45, 80, k);
      else       chk_all("post_clr_end", 1, 8, 1, 1, 0);
    end
    e = 1'b0;
    step();
    chk("post_clr.valid_drop", out_valid, 0);
    chk("clr.valid_count", nv, 1);

    // Reset mid-window drops the partial window and the published results
    e = 1'b1; y_in = 14'd5;
    step(); step(); step();
    rst_n = 1'b0;
    step();
    chk_all("mid_reset", 0, 0, 0, 0, 0);
    rst_n = 1'b1; e = 1'b0;
    step();
    chk("post_reset.win_cnt", win_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
